// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared TX scheduler state encoding and parameter defaults.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } sched_state_t;
  localparam int N_REQ_DEF    = 4;
  localparam int BUSY_TMO_DEF = 15;
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// uart_rr_pick: combinational round-robin search starting just after last_gnt.
module uart_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_gnt,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req[(int'(last_gnt) + i) % N_REQ]) win_idx = IW'((int'(last_gnt) + i) % N_REQ);
    win_oh = (|req) ? (N_REQ'(1) << win_idx) : '0;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding a UART transmitter.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 err_tmo,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 sched_busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TMO + 1);

  sched_state_t     r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_last, r_win, w_pick_idx;
  logic [N_REQ-1:0] r_win_oh, w_pick_oh, w_gnt_n, w_done_n;
  logic             w_grab, w_tmo, w_fin;

  uart_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req      (req),
    .last_gnt (r_last),
    .win_oh   (w_pick_oh),
    .win_idx  (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (|req && !tx_busy) ? START : IDLE;
      START:   w_next = WAIT_HI;
      WAIT_HI: w_next = tx_busy ? WAIT_LO : (w_tmo ? IDLE : WAIT_HI);
      WAIT_LO: w_next = tx_busy ? WAIT_LO : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next values of the pulse outputs; they are registered so each lands one cycle later.
  always_comb begin
    w_grab   = (r_state == IDLE) && |req && !tx_busy;
    w_tmo    = (r_state == WAIT_HI) && !tx_busy && (r_cnt == CW'(BUSY_TMO - 1));
    w_fin    = (r_state == WAIT_LO) && !tx_busy;
    w_gnt_n  = w_grab ? w_pick_oh : '0;
    w_done_n = w_fin ? r_win_oh : '0;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      gnt        <= '0;
      done       <= '0;
      err_tmo    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      sched_busy <= 1'b0;
      r_cnt      <= '0;
      r_last     <= IW'(N_REQ - 1);
      r_win      <= '0;
      r_win_oh   <= '0;
    end else begin
      gnt        <= w_gnt_n;
      done       <= w_done_n;
      err_tmo    <= w_tmo;
      tx_start   <= w_grab;
      sched_busy <= (w_next != IDLE);
      if (w_grab) begin
        r_win    <= w_pick_idx;
        r_win_oh <= w_pick_oh;
        tx_data  <= req_data[{w_pick_idx, 3'b000} +: 8];
      end
      if (r_state == START) begin
        r_last <= r_win;
        r_cnt  <= '0;
      end else if (r_state == WAIT_HI && !tx_busy) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of byte requesters (2..8).
REQ-002 Parameter BUSY_TMO, default 15, SHALL set the maximum cycles from tx_start until tx_busy is seen high.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  N_REQ  SHALL carry per-requester send requests, level, held until gnt.
REQ-006 req_data  input  8*N_REQ  SHALL carry flattened bytes; requester i uses bits [8i+7:8i].
REQ-007 gnt  output  N_REQ  SHALL be a one-hot, one-cycle pulse marking acceptance of requester i's byte.
REQ-008 done  output  N_REQ  SHALL be a one-hot, one-cycle pulse when requester i's frame has left the line.
REQ-009 err_tmo  output  1  SHALL be a one-cycle pulse on busy-timeout.
REQ-010 tx_start  output  1  SHALL be a one-cycle start strobe to the UART transmitter.
REQ-011 tx_data  output  8  SHALL be the byte presented to the transmitter's data input, stable from tx_start until done/err_tmo.
REQ-012 tx_busy  input  1  SHALL be the transmitter's busy flag.
REQ-013 sched_busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT_HI, WAIT_LO.
REQ-015 IDLE: when any req bit is high and tx_busy=0, the FSM SHALL register the round-robin winner and its byte, then move to START; otherwise stay.
REQ-016 Round-robin SHALL search from (last_gnt+1) mod N_REQ upward with wrap-around; after reset last_gnt = N_REQ-1, so requester 0 has first priority.
REQ-017 START (exactly one cycle): tx_start=1, gnt[winner]=1, last_gnt<=winner, counter<=0; next state WAIT_HI.
REQ-018 Latency: gnt/tx_start SHALL assert the cycle after IDLE first samples a qualifying req.
REQ-019 WAIT_HI: on tx_busy=1 go to WAIT_LO; else increment counter; when counter reaches BUSY_TMO, pulse err_tmo and go IDLE with no done pulse.
REQ-020 WAIT_LO: on tx_busy=0, pulse done[winner] and go IDLE.
REQ-021 The next grant SHALL occur no earlier than one cycle after done/err_tmo (IDLE re-evaluates).
REQ-022 A req dropped before grant SHALL be treated as withdrawn; req bits sampled in non-IDLE states SHALL be ignored.
REQ-023 tx_busy=1 while in IDLE SHALL block granting.
REQ-024 The winner's byte SHALL be captured at the IDLE->START transition; later req_data changes SHALL not affect tx_data.
REQ-025 Simultaneous requests SHALL be served one per frame in rotating order; no requester starves while held.
REQ-026 All outputs SHALL be registered; gnt, done, err_tmo, tx_start never multi-hot and never longer than one cycle.

Reset
REQ-027 On rstn low, state SHALL go to IDLE immediately; gnt=0, done=0, err_tmo=0, tx_start=0, tx_data=8'h00, sched_busy=0, counter=0, last_gnt=N_REQ-1.
REQ-028 Reset mid-frame SHALL abort without any done or err_tmo pulse; after release a new arbitration starts from requester 0.

Structure
REQ-029 State encodings (2 bits) and defaults for N_REQ and BUSY_TMO SHALL reside in a shared uart package/include used by the TX blocks.
REQ-030 The round-robin priority search SHALL be one sub-module, uart_rr_pick (inputs req, last_gnt; output one-hot winner and index), combinational.
REQ-031 uart_tx_sched SHALL connect to the existing transmitter top via tx_start, tx_data, tx_busy only.

Verification
REQ-032 Single req[0] with byte 8'hA5, transmitter model raises busy 1 cycle after tx_start for 10 cycles -> gnt[0] and tx_start at cycle 1, tx_data=8'hA5, done[0] one cycle after busy falls.
REQ-033 req=4'b1111 held, bytes 11/22/33/44 -> grants in order 0,1,2,3,0, each only after prior done.
REQ-034 last_gnt=2, req=4'b0101 -> requester 0 granted (wrap-around), then 2.
REQ-035 tx_busy stuck low after tx_start -> err_tmo exactly BUSY_TMO cycles after entering WAIT_HI, no done, FSM back to IDLE.
REQ-036 rstn asserted during WAIT_LO -> all outputs zero immediately, no done; after release with req=4'b1000 -> gnt[3] granted.
REQ-037 req_data[7:0] changed from 8'h5A to 8'hFF after gnt[0] -> tx_data stays 8'h5A until done[0].
